// File: rtl/spi_request_arbiter_pkg.sv
// Shared types and default widths for the SPI request arbiter slice.
package spi_arb_pkg;

    localparam int DATA_W = 8;
    localparam int SS_W   = 2;

    // All-ones slave select: no slave addressed, transfer is refused.
    localparam logic [SS_W-1:0] SS_NONE = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/spi_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    // Scan NUM_REQ positions starting at rr_ptr with wrap; the first hit wins.
    always_comb begin
        int unsigned pos;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(rr_ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld   = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Shares one SPI master among NUM_REQ requesters: round-robin accept, one
// start pulse per frame, response strobe back to the winner, idle gap after.
// Optional wait timeout enabled by defining SPI_TIMEOUT_EN.
module spi_request_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_W         = spi_arb_pkg::DATA_W,
    parameter  int SS_W           = spi_arb_pkg::SS_W,
    parameter  int GAP_CYCLES     = 2,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*SS_W-1:0]   req_slave_select,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      master_start,
    output logic [SS_W-1:0]           master_slave_select,
    output logic [DATA_W-1:0]         master_data_to_send,
    input  logic                      master_done,
    input  logic [DATA_W-1:0]         master_data_received,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    import spi_arb_pkg::*;

    localparam logic [SS_W-1:0] SS_ALL1 = '1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [SS_W-1:0]     ss_q, ss_d;
    logic [DATA_W-1:0]   txd_q, txd_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;
    logic [SS_W-1:0]     sel_ss;
    logic [DATA_W-1:0]   sel_data;
    logic                xfer_phase;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign sel_ss   = req_slave_select[32'(arb_idx)*SS_W +: SS_W];
    assign sel_data = req_data[32'(arb_idx)*DATA_W +: DATA_W];

    // Next-state logic: accept, launch, wait for done, respond, then idle gap.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        ss_d       = ss_q;
        txd_d      = txd_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef SPI_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_id_d = arb_idx;
                    ss_d       = sel_ss;
                    txd_d      = sel_data;
                    if (sel_ss == SS_ALL1) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d    = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef SPI_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                // Done has priority over a timeout expiring in the same cycle.
                if (master_done) begin
                    rsp_data_d = master_data_received;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
`ifdef SPI_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ST_RESP: begin
                rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
                if (GAP_CYCLES > 0) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            ss_q       <= '1;
            txd_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            gap_cnt_q  <= '0;
`ifdef SPI_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            ss_q       <= ss_d;
            txd_q      <= txd_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef SPI_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Master-side fields are only presented while a frame is in flight.
    assign xfer_phase          = (state_q == ST_START) || (state_q == ST_WAIT);
    assign master_slave_select = xfer_phase ? ss_q : SS_ALL1;
    assign master_data_to_send = xfer_phase ? txd_q : '0;
    assign master_start        = (state_q == ST_START);

    assign req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
    assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_id_q;

endmodule
